// File: rtl/store_buffer_pkg.sv
// Shared memory-control definitions: store opcodes, the store address-space
// qualifier and the big-endian byte-lane encoder used by the write-enable path.
package store_buffer_pkg;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2b;

  typedef struct packed {
    logic        is_store;
    logic [3:0]  we;
    logic [31:0] din;
  } lane_enc_t;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  we;
    logic [31:0] din;
  } sb_entry_t;

  // Writable space is addr[31:28] == 4'b0zz1.
  function automatic logic in_store_space(input logic [31:0] a);
    return (a[31] == 1'b0) && (a[28] == 1'b1);
  endfunction

  // Lane 3 (we[3]) is byte offset 0: big-endian lane mapping.
  function automatic lane_enc_t lane_encode(input logic [5:0]  op,
                                            input logic [1:0]  off,
                                            input logic [31:0] data);
    lane_enc_t e;
    e = '0;
    case (op)
      OP_SB: begin
        e.is_store = 1'b1;
        e.we       = 4'b1000 >> off;
        e.din      = {4{data[7:0]}};
      end
      OP_SH: begin
        e.is_store = 1'b1;
        e.we       = off[0] ? 4'b0011 : 4'b1100;
        e.din      = {2{data[15:0]}};
      end
      OP_SW: begin
        e.is_store = 1'b1;
        e.we       = 4'b1111;
        e.din      = data;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/store_lane_encode.sv
// Combinational SB/SH/SW decode into byte write enables and lane-replicated data.
module store_lane_encode
  import store_buffer_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  output logic [3:0]  we,
  output logic [31:0] din,
  output logic        is_store
);

  lane_enc_t enc;

  always_comb begin
    enc = lane_encode(opcode, offset, store_data);
  end

  assign we       = enc.we;
  assign din      = enc.din;
  assign is_store = enc.is_store;

endmodule

// File: rtl/store_buffer.sv
// Posted-store queue: qualifies and lane-encodes stores, drains them in program
// order over mem_req/mem_ack, and flags loads that hit a pending store word.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_we,
  input  logic        ld_check,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  // Handshakes: an input transfer happens on a rising edge where
  // in_valid & in_ready; a drain transfer where mem_req & mem_ack. Neither side
  // may change its presented payload while its valid is high and not accepted.

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  sb_entry_t        entries [DEPTH];

  logic [3:0]  enc_we;
  logic [31:0] enc_din;
  logic        enc_is_store;
  logic        push;
  logic        pop;

  store_lane_encode u_encode (
    .opcode     (opcode),
    .offset     (addr[1:0]),
    .store_data (store_data),
    .we         (enc_we),
    .din        (enc_din),
    .is_store   (enc_is_store)
  );

  assign in_ready = (count != FULL_CNT);
  assign mem_req  = (count != '0);
  assign empty    = (count == '0);

  // Non-store or out-of-space instructions are still consumed, just not queued.
  assign push = in_valid & in_ready & enc_is_store & in_store_space(addr);
  assign pop  = mem_req & mem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload is deliberately unreset; the outputs below mask it when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= '{waddr: addr[31:2], we: enc_we, din: enc_din};
    end
  end

  assign mem_addr = mem_req ? {entries[head].waddr, 2'b00} : '0;
  assign mem_din  = mem_req ? entries[head].din : '0;
  assign mem_we   = mem_req ? entries[head].we  : '0;

  logic             word_hit;
  logic [PTR_W-1:0] slot_off;
  logic             ld_offset_unused;

  assign ld_offset_unused = ^ld_addr[1:0];

  // A slot is live when its distance from head is below count.
  always_comb begin
    word_hit = 1'b0;
    slot_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PTR_W'(i) - head;
      if (({1'b0, slot_off} < count) && (entries[i].waddr == ld_addr[31:2])) begin
        word_hit = 1'b1;
      end
    end
  end

  assign ld_hazard = ld_check & in_store_space(ld_addr) & word_hit;

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-store queue between the execute stage and the data-memory/IO write port. Qualifies and byte-lane-encodes SB/SH/SW using the big-endian lane mapping of the write-enable decoder. It buffers up to DEPTH stores and drains them to memory over a req/ack handshake, so the pipeline stalls only when the buffer is full or a load hits a pending store.

## Interface
- DEPTH, 4: entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH): pointer width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; one clock, asynchronous and active-low.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  buffer can accept; low stalls the pipeline.
- opcode  in  6  instruction opcode; SB/SH/SW from the shared opcode header.
- addr  in  32  effective address (ALU output).
- store_data  in  32  rt value; the low byte or halfword is used for SB/SH.
- mem_req  out  1  head entry valid and presented.
- mem_ack  in  1  memory accepted head entry this cycle.
- mem_addr  out  32  word address of head entry, {addr[31:2],2'b00}.
- mem_din  out  32  lane-aligned write data.
- mem_we  out  4  byte write enables; bit 3 = addr offset 0.
- ld_check  in  1  a load in execute wants memory this cycle.
- ld_addr  in  32  that load's effective address.
- ld_hazard  out  1  load's word matches a buffered store; hold the load.
- empty  out  1  no buffered stores; used for fences/IO ordering.

## Operation
- Qualify: enqueue only if in_valid & in_ready & opcode ∈ {SB,SH,SW} & addr[31:28] matches 4'b0zz1. Every other accepted instruction is consumed with no effect.
- Lane encoding (offset = addr[1:0]):
  - SB: we = 1000/0100/0010/0001 for offsets 00/01/10/11; din = {4{store_data[7:0]}}.
  - SH: we = 1100 if offset[0] = 0, else 0011; din = {2{store_data[15:0]}}.
  - SW: we = 1111; din = store_data.
- Entry = {word addr[31:2], we, din}. Circular buffer with head/tail pointers and a count of width PTR_W+1. Pointers wrap modulo DEPTH.
- in_ready = (count != DEPTH). A full buffer refuses input even if mem_ack is high the same cycle; no bypass.
- Drain: mem_req = (count != 0). mem_addr/mem_din/mem_we show the head entry and hold stable while mem_req & !mem_ack.
- On mem_ack & mem_req: pop the head. mem_ack while mem_req = 0 is ignored.
- Simultaneous enqueue and pop: count unchanged, both pointers advance.
- ld_hazard = ld_check & ld_addr in space & a valid entry has entry.addr[31:2] == ld_addr[31:2]. Combinational over all valid entries, including the head being acked this cycle. A store enqueuing this same cycle is not compared.
- empty = (count == 0).

## Timing
- Reset (rst low, asynchronous): count = 0 and head = tail = 0, so mem_req = 0, in_ready = 1, empty = 1, ld_hazard = 0. mem_addr/mem_din/mem_we read 0. Entry payload is not reset.
- Reset during a pending mem_req drops mem_req immediately and discards all entries.
- Enqueue-to-memory latency: 1 cycle. A store accepted at edge N drives mem_req from after edge N; the earliest pop is at edge N+1.
- Throughput: 1 store/cycle sustained when mem_ack is held high.
- Stores drain strictly in program order. No merging or coalescing.
- in_ready, mem_req and empty derive from registered count only. ld_hazard is combinational from ld_* inputs and registered entries.

## Structure
- Qualifier predicate and lane-encode function go in the shared memory-control package/header, alongside the opcode defines, so the write-enable decoder and this block share one definition.
- One sub-module: store_lane_encode (combinational: opcode, addr[1:0], store_data → we, din, is_store). Queue, pointers and hazard compare stay in store_buffer.

## Test plan
- Encode: SB addr 0x1000_0002 data 0xAB → mem_addr 0x1000_0000, mem_we 0010, mem_din 0xABAB_ABAB; SH 0x1000_0001 data 0x1234 → we 0011, din 0x1234_1234.
- Filter: SW to 0x2000_0000, LW to 0x1000_0000, and SW with in_valid = 0 → nothing enqueued; empty stays 1.
- Fill/backpressure: DEPTH = 4, mem_ack = 0, five SWs → in_ready falls after the 4th; the 5th is held. One mem_ack → in_ready rises next cycle; the 5th is accepted and order is preserved (addresses 0x1000_0000..0x1000_0010).
- Simultaneous enqueue and ack with count = 2 → count stays 2 and pointers wrap correctly across 8 consecutive operations.
- Hazard: buffered SB 0x1000_0043; ld_check with ld_addr 0x1000_0040 → ld_hazard = 1; ld_addr 0x1000_0044 → 0; after that entry is acked → 0.
- Async reset with 3 entries and mem_req high → mem_req = 0 and in_ready = 1 before the next clock edge; the post-reset store drains alone.
